// File: rtl/hall_effect_sensor.sv
// Hall-sensor commutation for a 3-phase bridge: synchronizes and debounces the hall code,
// then maps it to per-phase high/low/float drive with dead time between differing patterns.
module hall_effect_sensor #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned DEAD_TIME       = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] h,
  output logic [2:0] u,
  output logic [2:0] z
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DtW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES);
  localparam logic [DtW-1:0] DtLoad = DtW'(DEAD_TIME);
  localparam logic [5:0] AllFloat = 6'b000_111;

  logic [2:0]     s1_q, s2_q;
  logic [2:0]     cand_q, cand_d;
  logic [DbW-1:0] dbc_q, dbc_d;
  logic [2:0]     acc_q, acc_d;
  logic [DtW-1:0] dtc_q, dtc_d;
  logic [2:0]     u_q, u_d;
  logic [2:0]     z_q, z_d;
  logic           accept;
  logic           changed;

  // Returns {u, z} for a hall code; invalid codes float every phase.
  function automatic logic [5:0] drive_pattern(input logic [2:0] c);
    logic [5:0] p;
    case (c)
      3'b101:  p = 6'b001_100;
      3'b100:  p = 6'b001_010;
      3'b110:  p = 6'b010_001;
      3'b010:  p = 6'b010_100;
      3'b011:  p = 6'b100_010;
      3'b001:  p = 6'b100_001;
      default: p = AllFloat;
    endcase
    return p;
  endfunction

  function automatic logic code_valid(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  always_comb begin
    cand_d = cand_q;
    dbc_d  = dbc_q;
    acc_d  = acc_q;
    dtc_d  = dtc_q;
    u_d    = u_q;
    z_d    = z_q;

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      dbc_d  = DbW'(1);
    end else if (dbc_q < DbMax) begin
      dbc_d = dbc_q + DbW'(1);
    end

    // Fires once per stable run: on the edge the run length first reaches the threshold.
    accept  = (dbc_d == DbMax) && ((dbc_d != dbc_q) || (s2_q != cand_q));
    changed = accept && (s2_q != acc_q);

    if (changed) begin
      acc_d = s2_q;
      if (!code_valid(s2_q)) begin
        {u_d, z_d} = AllFloat;
        dtc_d      = '0;
      end else if (DEAD_TIME == 0) begin
        {u_d, z_d} = drive_pattern(s2_q);
        dtc_d      = '0;
      end else begin
        {u_d, z_d} = AllFloat;
        dtc_d      = DtLoad;
      end
    end else if (dtc_q != '0) begin
      dtc_d = dtc_q - DtW'(1);
      if (dtc_q == DtW'(1)) begin
        {u_d, z_d} = drive_pattern(acc_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= 3'b000;
      s2_q   <= 3'b000;
      cand_q <= 3'b000;
      dbc_q  <= '0;
      acc_q  <= 3'b000;
      dtc_q  <= '0;
      u_q    <= 3'b000;
      z_q    <= 3'b111;
    end else begin
      s1_q   <= h;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      dbc_q  <= dbc_d;
      acc_q  <= acc_d;
      dtc_q  <= dtc_d;
      u_q    <= u_d;
      z_q    <= z_d;
    end
  end

  assign u = u_q;
  assign z = z_q;

endmodule

// File: tb/tb_hall_effect_sensor.sv
// Bench for hall_effect_sensor: directed vector table, hand-written corner sequences and
// randomized hall codes compared each cycle against an event-level reference model.
module tb_hall_effect_sensor;

  localparam int Deb = 2;
  localparam int Dt  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] h;
  logic [2:0] u, z;

  int nvec = 0;
  int nerr = 0;

  hall_effect_sensor #(
    .DEBOUNCE_CYCLES(Deb),
    .DEAD_TIME      (Dt)
  ) dut (
    .clock(clock),
    .reset(reset),
    .h    (h),
    .u    (u),
    .z    (z)
  );

  always #5 clock = ~clock;

  // Reference model: h sampled two edges ago is what the debouncer sees; a run of Deb
  // identical samples accepts a code; a differing valid code schedules its pattern Dt edges later.
  logic [2:0] m_h1, m_h2, m_run, m_acc, m_u, m_z;
  int         m_len;
  int         m_edge = 0;
  int         m_deadline = -1;

  function automatic logic [5:0] model_pat(input logic [2:0] c);
    int hi, fl;
    case (c)
      3'b101:  begin hi = 0; fl = 2; end
      3'b100:  begin hi = 0; fl = 1; end
      3'b110:  begin hi = 1; fl = 0; end
      3'b010:  begin hi = 1; fl = 2; end
      3'b011:  begin hi = 2; fl = 1; end
      3'b001:  begin hi = 2; fl = 0; end
      default: return 6'b000_111;
    endcase
    return {3'(1 << hi), 3'(1 << fl)};
  endfunction

  task automatic model_edge(input logic [2:0] hv, input logic rv);
    logic [2:0] sample;
    m_edge++;
    if (rv) begin
      m_h1 = 0; m_h2 = 0; m_run = 0; m_len = 0; m_acc = 0;
      m_deadline = -1; m_u = 3'b000; m_z = 3'b111;
    end else begin
      sample = m_h2;
      m_h2   = m_h1;
      m_h1   = hv;
      if (sample == m_run) m_len++;
      else begin m_run = sample; m_len = 1; end
      if (m_len == Deb && sample != m_acc) begin
        m_acc = sample;
        m_deadline = -1;
        if (sample == 3'b000 || sample == 3'b111) {m_u, m_z} = 6'b000_111;
        else if (Dt == 0) {m_u, m_z} = model_pat(sample);
        else begin
          {m_u, m_z} = 6'b000_111;
          m_deadline = m_edge + Dt;
        end
      end else if (m_deadline == m_edge) begin
        {m_u, m_z} = model_pat(m_acc);
        m_deadline = -1;
      end
    end
  endtask

  task automatic check(input string name, input logic [2:0] eu, input logic [2:0] ez);
    nvec++;
    if (u !== eu || z !== ez) begin
      nerr++;
      $display("FAIL %s @%0t: got u=%b z=%b, want u=%b z=%b", name, $time, u, z, eu, ez);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Drive one cycle, advance the model, compare #1 after the edge.
  task automatic step(input logic [2:0] hv, input logic rv);
    h = hv;
    reset = rv;
    @(posedge clock);
    model_edge(hv, rv);
    #1;
    check("model", m_u, m_z);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] h;
    logic [2:0] eu;
    logic [2:0] ez;
  } vec_t;

  vec_t       tbl[13];
  logic [2:0] codes[6];
  logic [5:0] rows[6];

  initial begin
    int nfloat;
    int hold;
    logic [2:0] c;
    logic r;

    // Reset 3 cycles, idle at 000, then 101 held: float through edge 4, pattern after edge 5.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 3'b000, 3'b000, 3'b111};
    for (int i = 3; i < 6; i++) tbl[i] = '{1'b0, 3'b000, 3'b000, 3'b111};
    for (int i = 6; i < 11; i++) tbl[i] = '{1'b0, 3'b101, 3'b000, 3'b111};
    for (int i = 11; i < 13; i++) tbl[i] = '{1'b0, 3'b101, 3'b001, 3'b100};

    codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    rows  = '{6'b001_100, 6'b001_010, 6'b010_001, 6'b010_100, 6'b100_010, 6'b100_001};

    h = 3'b000;
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].h, tbl[i].rst);
      check($sformatf("table[%0d]", i), tbl[i].eu, tbl[i].ez);
    end

    // Walk the commutation sequence; exactly Dt float cycles between adjacent rows.
    for (int k = 1; k < 6; k++) begin
      nfloat = 0;
      for (int i = 0; i < 20; i++) begin
        step(codes[k], 1'b0);
        if (u == 3'b000 && z == 3'b111) nfloat++;
      end
      check_int($sformatf("deadtime_row%0d", k), nfloat, Dt);
      check($sformatf("row%0d", k), rows[k][5:3], rows[k][2:0]);
      check_int($sformatf("roles_row%0d", k),
                $countones(u) * 10 + $countones(z) + ((u & z) != 0 ? 100 : 0), 11);
    end

    // One-cycle glitch to 010 while 110 is applied must not disturb the outputs.
    for (int i = 0; i < 10; i++) step(3'b110, 1'b0);
    check("glitch_pre", 3'b010, 3'b001);
    step(3'b010, 1'b0);
    check("glitch_0", 3'b010, 3'b001);
    for (int i = 0; i < 12; i++) begin
      step(3'b110, 1'b0);
      check($sformatf("glitch_%0d", i + 1), 3'b010, 3'b001);
    end

    // Invalid code while 011 is applied floats on the acceptance edge with no dead time.
    for (int i = 0; i < 8; i++) step(3'b011, 1'b0);
    check("inv_pre", 3'b100, 3'b010);
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 1'b0);
      if (i < 3) check($sformatf("inv_edge%0d", i), 3'b100, 3'b010);
      else       check("inv_accept", 3'b000, 3'b111);
    end

    // Reset during dead time, then full re-acquisition of the held code.
    for (int i = 0; i < 4; i++) step(3'b101, 1'b0);
    check("dt_window", 3'b000, 3'b111);
    step(3'b101, 1'b1);
    check("dt_reset", 3'b000, 3'b111);
    for (int i = 0; i < 7; i++) begin
      step(3'b101, 1'b0);
      if (i < 5) check($sformatf("reacq_edge%0d", i), 3'b000, 3'b111);
      else       check($sformatf("reacq_edge%0d", i), 3'b001, 3'b100);
    end

    // Random codes with random hold lengths (short holds act as glitches) and rare resets.
    for (int n = 0; n < 800; n++) begin
      c = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        r = ($urandom_range(0, 99) < 2);
        step(c, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
